hba_quad: RTL and testbench
===========================

Name: hba_quad

Overview:
- HBA bus slave peripheral that decodes two quadrature encoders (left = channel 0, right = channel 1) in x4 mode.
- Each channel keeps a 16-bit signed position count, readable byte-wise with an atomic high-byte shadow.
- Reports change and error status, and raises an interrupt for the serial_fpga interrupt controller.
- Occupies a free slot of hba_system (PERIPH_ADDR parameter); its dbus and xferack outputs feed hba_or_slaves.

Parameters:
- DBUS_WIDTH, 8, data bus width (block requires 8).
- PERIPH_ADDR_WIDTH, 4, peripheral-select field width.
- REG_ADDR_WIDTH, 8, register-address field width.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, full address width.
- PERIPH_ADDR, 5, slot number this block answers to.

Ports:
- hba_clk  in  1  system clock; all logic on the rising edge.
- hba_reset  in  1  asynchronous, active-low reset (0 = reset).
- hba_rnw  in  1  1 = read, 0 = write.
- hba_select  in  1  transfer in progress.
- hba_abus  in  ADDR_WIDTH  address; upper PERIPH_ADDR_WIDTH bits = slot, lower = register.
- hba_dbus  in  DBUS_WIDTH  write data.
- hba_dbus_slave  out  DBUS_WIDTH  read data; 0 when not acking.
- hba_xferack_slave  out  1  one-cycle transfer acknowledge; 0 when inactive.
- slave_interrupt  out  1  level interrupt request.
- quad_enc_a  in  2  encoder A phase, per channel.
- quad_enc_b  in  2  encoder B phase, per channel.

Behaviour:
- Reset: all outputs 0; counts, shadows, CTRL and STATUS are 0; synchronizer flops are 0.
- Bus decode: hit = hba_select & (abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR).
  - On hit & !xferack, register xferack = 1 for the following cycle. Exactly one cycle per transfer, then 0 while select stays high.
  - Read data is registered in the same edge, so it is valid only while xferack = 1; otherwise 0.
  - Write data is captured at that same edge.
  - Read side effects (shadow latch, status clear) occur once, at that edge.
- Register map:
  - 0 CTRL (r/w): [0] en0, [1] en1, [2] intr_en, [3] clear. clear is write-1, self-clearing; it zeroes both counts and shadows on the next edge and always reads 0.
  - 1 CNT0_LO (r): returns the live count0[7:0] and copies count0[15:8] into shadow0 in the same cycle.
  - 2 CNT0_HI (r): returns shadow0.
  - 3 CNT1_LO, 4 CNT1_HI: same scheme for channel 1.
  - 5 STATUS (r, clear-on-read): [0] chg0, [1] chg1, [2] err0, [3] err1.
  - Other addresses read 0; writes to them and to read-only registers are ignored; a plain ack is still given.
- Input path, per channel:
  - {a,b} passes a 2-flop synchronizer, then a previous-state register.
  - A count update lands 3 clocks after the pin edge.
- Decode ({a,b} prev→cur):
  - Increment: 00→10→11→01→00.
  - Decrement: the reverse sequence.
  - No change: count holds.
  - Both bits changed: illegal; no count change, err bit set.
  - Disabled channel (enN = 0): the previous-state register still tracks; count, chg and err do not update.
- Arithmetic: 16-bit two's complement, wraps modulo 2^16 (0xFFFF +1 → 0x0000; 0x0000 −1 → 0xFFFF).
- chgN sets on any count step.
- Simultaneous events:
  - clear vs step in the same cycle: clear wins; count = 0.
  - STATUS read vs new set event in the same cycle: the set wins; the bit stays 1 and the read returns the prior value.
  - CNT_LO read vs step in the same cycle: the returned low byte and the latched high byte both come from the pre-step count.
- slave_interrupt = intr_en & (chg0 | chg1 | err0 | err1), registered; one cycle latency after the status or CTRL update.
- Reset asserted mid-transfer: xferack and dbus_slave drop to 0 immediately (asynchronous).

Decomposition:
- Package hba_quad_pkg:
  - register address localparams (REG_CTRL..REG_STATUS);
  - CTRL and STATUS bit indices;
  - 2-bit step encoding (STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR).
- Sub-module quad_decoder, instantiated once per channel: synchronizer, previous-state register, step/err decode, 16-bit counter with enable and clear inputs.
- The top level holds the bus FSM, shadows, CTRL/STATUS and the interrupt.

Test Plan:
- Reset then read every register 0–5 → each returns 0x00 with a single-cycle xferack; slave_interrupt = 0.
- Set CTRL = 0x01, drive ch0 through 8 forward steps → CNT0_LO = 0x08, CNT0_HI = 0x00, STATUS = 0x01; a second STATUS read returns 0x00.
- From count 0, drive 1 reverse step on ch0 → LO = 0xFF. Then move forward 300 steps (net count 299 = 0x012B) and read LO → 0x2B; apply 256 more steps, then read HI → 0x01 (shadow, not the live 0x02).
- Jump ch1 pins 00→11 with en1 = 1 → count unchanged, STATUS = 0x08. With intr_en = 1, slave_interrupt = 1 until STATUS is read.
- Write CTRL = 0x0B while ch0 is stepping forward every 2 cycles → CNT0 reads 0x0000 or 0x0001 just after; CTRL reads back 0x03.
- Hold select for 5 cycles with a mismatched PERIPH_ADDR → xferack_slave and dbus_slave stay 0; assert reset mid-ack → both drop to 0 at once.

Source files
------------

// File: rtl/hba_quad_pkg.sv
// Shared constants for the HBA quadrature-encoder peripheral: register map,
// CTRL/STATUS bit positions and the per-sample step classification.
package hba_quad_pkg;

    localparam int REG_CTRL    = 0;
    localparam int REG_CNT0_LO = 1;
    localparam int REG_CNT0_HI = 2;
    localparam int REG_CNT1_LO = 3;
    localparam int REG_CNT1_HI = 4;
    localparam int REG_STATUS  = 5;

    localparam int CTRL_EN0  = 0;
    localparam int CTRL_EN1  = 1;
    localparam int CTRL_INTR = 2;
    localparam int CTRL_CLR  = 3;

    localparam int ST_CHG0 = 0;
    localparam int ST_CHG1 = 1;
    localparam int ST_ERR0 = 2;
    localparam int ST_ERR1 = 3;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Position of {a,b} along the forward cycle 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    // Distance of 1 forward = inc, 3 (i.e. -1) = dec, 2 = both bits flipped.
    function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        case (d)
            2'd0:    quad_step = STEP_NONE;
            2'd1:    quad_step = STEP_INC;
            2'd3:    quad_step = STEP_DEC;
            default: quad_step = STEP_ERR;
        endcase
    endfunction

endpackage

// File: rtl/hba_quad_decoder.sv
// One quadrature channel: 2-flop synchronizer, previous-state register,
// x4 step decode and a wrapping 16-bit position counter.
module quad_decoder
    import hba_quad_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        a_i,
    input  logic        b_i,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [15:0] count_o,
    output logic        step_o,
    output logic        err_o
);

    logic [1:0]  sync1_q, sync2_q, prev_q;
    logic [15:0] count_q, count_d;
    step_e       step;

    assign step = quad_step(prev_q, sync2_q);

    // Synchronize pins; prev tracks even when the channel is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Clear dominates any step landing on the same edge.
    always_comb begin
        count_d = count_q;
        if (clr_i)                          count_d = 16'h0000;
        else if (en_i && step == STEP_INC)  count_d = count_q + 16'd1;
        else if (en_i && step == STEP_DEC)  count_d = count_q - 16'd1;
    end

    // Position counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= 16'h0000;
        else         count_q <= count_d;
    end

    assign count_o = count_q;
    assign step_o  = en_i && (step == STEP_INC || step == STEP_DEC);
    assign err_o   = en_i && (step == STEP_ERR);

endmodule

// File: rtl/hba_quad.sv
// HBA bus slave wrapping two quadrature decoders: byte-wide count readout
// with an atomic high-byte shadow, clear-on-read status and a level IRQ.
module hba_quad
    import hba_quad_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 5
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    input  logic                  hba_rnw,
    input  logic                  hba_select,
    input  logic [ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
    output logic                  hba_xferack_slave,
    output logic                  slave_interrupt,
    input  logic [1:0]            quad_enc_a,
    input  logic [1:0]            quad_enc_b
);

    logic [REG_ADDR_WIDTH-1:0] reg_a;
    logic                      hit, xfer, rd, wr;
    logic                      ack_q, ack_d, irq_q, irq_d, clr_q, clr_d;
    logic [DBUS_WIDTH-1:0]     dbus_q, dbus_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic [3:0]                st_q, st_d;
    logic [1:0][7:0]           shd_q, shd_d;
    logic [1:0][15:0]          cnt;
    logic [1:0]                step, err;
    logic                      unused_dbus;

    assign unused_dbus = ^hba_dbus[DBUS_WIDTH-1:4];
    assign reg_a = hba_abus[REG_ADDR_WIDTH-1:0];
    assign hit   = hba_select &&
                   (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    assign xfer  = hit && !ack_q;
    assign rd    = xfer && hba_rnw;
    assign wr    = xfer && !hba_rnw;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        quad_decoder u_dec (
            .clk_i   (hba_clk),
            .rst_ni  (hba_reset),
            .a_i     (quad_enc_a[ch]),
            .b_i     (quad_enc_b[ch]),
            .en_i    (ctrl_q[ch]),
            .clr_i   (clr_q),
            .count_o (cnt[ch]),
            .step_o  (step[ch]),
            .err_o   (err[ch])
        );
    end

    // Bus transfer, register side effects, status accumulation and IRQ.
    always_comb begin
        ack_d  = xfer;
        dbus_d = '0;
        ctrl_d = ctrl_q;
        clr_d  = 1'b0;
        shd_d  = shd_q;
        st_d   = st_q;
        if (rd) begin
            case (reg_a)
                REG_ADDR_WIDTH'(REG_CTRL):    dbus_d = DBUS_WIDTH'(ctrl_q);
                REG_ADDR_WIDTH'(REG_CNT0_LO): begin
                    dbus_d   = cnt[0][7:0];
                    shd_d[0] = cnt[0][15:8];
                end
                REG_ADDR_WIDTH'(REG_CNT0_HI): dbus_d = shd_q[0];
                REG_ADDR_WIDTH'(REG_CNT1_LO): begin
                    dbus_d   = cnt[1][7:0];
                    shd_d[1] = cnt[1][15:8];
                end
                REG_ADDR_WIDTH'(REG_CNT1_HI): dbus_d = shd_q[1];
                REG_ADDR_WIDTH'(REG_STATUS): begin
                    dbus_d = DBUS_WIDTH'(st_q);
                    st_d   = 4'b0000;
                end
                default: dbus_d = '0;
            endcase
        end
        if (wr && reg_a == REG_ADDR_WIDTH'(REG_CTRL)) begin
            ctrl_d = hba_dbus[2:0];
            clr_d  = hba_dbus[CTRL_CLR];
        end
        if (clr_q) shd_d = '0;
        // New events override a same-cycle clear-on-read.
        st_d[ST_CHG0] = st_d[ST_CHG0] | step[0];
        st_d[ST_CHG1] = st_d[ST_CHG1] | step[1];
        st_d[ST_ERR0] = st_d[ST_ERR0] | err[0];
        st_d[ST_ERR1] = st_d[ST_ERR1] | err[1];
        irq_d = ctrl_q[CTRL_INTR] && (st_q != 4'b0000);
    end

    // State registers; reset clears outputs immediately.
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            ack_q  <= 1'b0;
            dbus_q <= '0;
            ctrl_q <= 3'b000;
            clr_q  <= 1'b0;
            shd_q  <= '0;
            st_q   <= 4'b0000;
            irq_q  <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            dbus_q <= dbus_d;
            ctrl_q <= ctrl_d;
            clr_q  <= clr_d;
            shd_q  <= shd_d;
            st_q   <= st_d;
            irq_q  <= irq_d;
        end
    end

    assign hba_dbus_slave    = dbus_q;
    assign hba_xferack_slave = ack_q;
    assign slave_interrupt   = irq_q;

endmodule

// File: tb/tb_hba_quad.sv
// Directed + randomized bench for hba_quad with a net-step reference model.
module tb_hba_quad;

    localparam int PA = 5;

    logic        hba_clk = 1'b0;
    logic        hba_reset, hba_rnw, hba_select;
    logic [11:0] hba_abus;
    logic [7:0]  hba_dbus, hba_dbus_slave;
    logic        hba_xferack_slave, slave_interrupt;
    logic [1:0]  quad_enc_a, quad_enc_b;

    hba_quad dut (
        .hba_clk           (hba_clk),
        .hba_reset         (hba_reset),
        .hba_rnw           (hba_rnw),
        .hba_select        (hba_select),
        .hba_abus          (hba_abus),
        .hba_dbus          (hba_dbus),
        .hba_dbus_slave    (hba_dbus_slave),
        .hba_xferack_slave (hba_xferack_slave),
        .slave_interrupt   (slave_interrupt),
        .quad_enc_a        (quad_enc_a),
        .quad_enc_b        (quad_enc_b)
    );

    always #5 hba_clk = ~hba_clk;

    int n_pass = 0, n_total = 0;

    // Reference model: net counts, shadows, sticky flags, encoder phase.
    logic [15:0] m_cnt [2];
    logic [7:0]  m_shd [2];
    logic [3:0]  m_st;
    logic [2:0]  m_ctrl;
    int          m_pos [2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt[0] = 0; m_cnt[1] = 0; m_shd[0] = 0; m_shd[1] = 0;
        m_st = 0; m_ctrl = 0;
    endtask

    task automatic drive_pins(input int ch);
        quad_enc_a[ch] = (m_pos[ch] == 1 || m_pos[ch] == 2);
        quad_enc_b[ch] = (m_pos[ch] == 2 || m_pos[ch] == 3);
    endtask

    task automatic step(input int ch, input int dir);
        m_pos[ch] = (m_pos[ch] + dir) & 3;
        drive_pins(ch);
        if (m_ctrl[ch]) begin
            m_cnt[ch] = m_cnt[ch] + 16'(dir);
            m_st[ch]  = 1'b1;
        end
    endtask

    task automatic jump(input int ch);
        m_pos[ch] = (m_pos[ch] + 2) & 3;
        drive_pins(ch);
        if (m_ctrl[ch]) m_st[2+ch] = 1'b1;
    endtask

    task automatic settle();
        repeat (5) @(negedge hba_clk);
    endtask

    // Called at a negedge; returns at a negedge with select released.
    task automatic bus_rd(input int ra, output logic [7:0] d);
        hba_select = 1; hba_rnw = 1; hba_abus = {4'(PA), 8'(ra)};
        @(posedge hba_clk); #1;
        chk("rd_ack", 16'(hba_xferack_slave), 16'd1);
        d = hba_dbus_slave;
        @(posedge hba_clk); #1;
        chk("rd_ack_drop", 16'({hba_xferack_slave, hba_dbus_slave}), 16'd0);
        @(negedge hba_clk);
        hba_select = 0;
    endtask

    task automatic bus_wr(input int ra, input logic [7:0] d);
        hba_select = 1; hba_rnw = 0; hba_abus = {4'(PA), 8'(ra)}; hba_dbus = d;
        @(posedge hba_clk); #1;
        chk("wr_ack", 16'(hba_xferack_slave), 16'd1);
        @(posedge hba_clk);
        @(negedge hba_clk);
        hba_select = 0;
        if (ra == 0) begin
            m_ctrl = d[2:0];
            if (d[3]) begin
                m_cnt[0] = 0; m_cnt[1] = 0; m_shd[0] = 0; m_shd[1] = 0;
            end
        end
    endtask

    task automatic rd_chk(input int ra);
        logic [7:0] exp, d;
        case (ra)
            0: exp = {5'b0, m_ctrl};
            1: exp = m_cnt[0][7:0];
            2: exp = m_shd[0];
            3: exp = m_cnt[1][7:0];
            4: exp = m_shd[1];
            5: exp = {4'b0, m_st};
            default: exp = 8'h00;
        endcase
        bus_rd(ra, d);
        chk($sformatf("reg%0d", ra), 16'(d), 16'(exp));
        if (ra == 1) m_shd[0] = m_cnt[0][15:8];
        if (ra == 3) m_shd[1] = m_cnt[1][15:8];
        if (ra == 5) m_st = 0;
    endtask

    task automatic chk_irq(input string tag);
        chk(tag, 16'(slave_interrupt), 16'(m_ctrl[2] && (m_st != 0)));
    endtask

    initial begin
        logic [7:0] lo, hi;
        hba_reset = 0; hba_rnw = 0; hba_select = 0; hba_abus = 0; hba_dbus = 0;
        quad_enc_a = 0; quad_enc_b = 0;
        m_pos[0] = 0; m_pos[1] = 0;
        model_reset();
        repeat (3) @(negedge hba_clk);
        hba_reset = 1;
        @(negedge hba_clk);

        // Reset state and full register sweep.
        chk("rst_out", 16'({hba_xferack_slave, slave_interrupt, hba_dbus_slave}), 16'd0);
        for (int r = 0; r <= 6; r++) rd_chk(r);

        // Eight forward steps on ch0, status clears on read.
        bus_wr(0, 8'h01);
        for (int i = 0; i < 8; i++) begin step(0, 1); @(negedge hba_clk); @(negedge hba_clk); end
        settle();
        rd_chk(1); rd_chk(2); rd_chk(5); rd_chk(5);

        // Wrap below zero, then shadow holds high byte across further steps.
        bus_wr(0, 8'h09); settle();
        step(0, -1); settle();
        rd_chk(1);
        for (int i = 0; i < 300; i++) begin step(0, 1); @(negedge hba_clk); end
        settle();
        rd_chk(1);
        for (int i = 0; i < 256; i++) begin step(0, 1); @(negedge hba_clk); end
        settle();
        rd_chk(2);
        rd_chk(5);

        // Illegal jump on ch1 raises err1 and the interrupt.
        bus_wr(0, 8'h07); settle();
        jump(1); settle();
        chk_irq("irq_err");
        rd_chk(5);
        repeat (2) @(negedge hba_clk);
        chk_irq("irq_clr");
        rd_chk(3); rd_chk(4);

        // Randomized steps, jumps and enable patterns.
        for (int rnd = 0; rnd < 6; rnd++) begin
            bus_wr(0, {5'b0, 3'($urandom_range(0, 7))}); settle();
            for (int e = 0; e < 12; e++) begin
                int ch, k;
                ch = $urandom_range(0, 1);
                k  = $urandom_range(0, 9);
                if (k < 2) jump(ch);
                else       step(ch, (k < 6) ? 1 : -1);
                @(negedge hba_clk); @(negedge hba_clk);
            end
            settle();
            chk_irq("irq_rnd");
            rd_chk(1); rd_chk(3); rd_chk(2); rd_chk(4); rd_chk(5);
            repeat (2) @(negedge hba_clk);
            chk_irq("irq_rnd_clr");
        end

        // Clear while ch0 steps every 2 cycles.
        bus_wr(0, 8'h01); settle();
        step(0, 1); @(negedge hba_clk); @(negedge hba_clk);
        step(0, 1); @(negedge hba_clk); @(negedge hba_clk);
        step(0, 1);
        bus_wr(0, 8'h0B);
        settle();
        bus_rd(1, lo); bus_rd(2, hi);
        chk("clr_race", 16'({hi, lo} == 16'h0000 || {hi, lo} == 16'h0001), 16'd1);
        bus_wr(0, 8'h0B); settle();
        rd_chk(0); rd_chk(1); rd_chk(5);

        // Foreign slot: no ack, no data.
        hba_select = 1; hba_rnw = 1; hba_abus = {4'd3, 8'd0};
        for (int i = 0; i < 5; i++) begin
            @(posedge hba_clk); #1;
            chk("foreign", 16'({hba_xferack_slave, hba_dbus_slave}), 16'd0);
        end
        @(negedge hba_clk); hba_select = 0;

        // Reset during an ack.
        @(negedge hba_clk);
        hba_select = 1; hba_rnw = 1; hba_abus = {4'(PA), 8'd0};
        @(posedge hba_clk); #1;
        chk("pre_rst_data", 16'({hba_xferack_slave, hba_dbus_slave}), 16'({1'b1, 5'b0, m_ctrl}));
        #1 hba_reset = 0;
        #1 chk("rst_mid", 16'({hba_xferack_slave, hba_dbus_slave}), 16'd0);
        @(negedge hba_clk);
        hba_select = 0; hba_reset = 1; model_reset();
        settle();
        rd_chk(0); rd_chk(1); rd_chk(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
